// File: rtl/hazard_pkg.sv
// Shared types and decode helpers for the decode-to-writeback control pipeline.
// Pure declarations; no state, no latency.
// No flow control of its own.
package hazard_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_CSR = 2'd3
   } wb_sel_e;

   localparam logic [6:0] OP     = 7'h33;
   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] BRANCH = 7'h63;
   localparam logic [6:0] JAL    = 7'h6F;
   localparam logic [6:0] JALR   = 7'h67;
   localparam logic [6:0] LUI    = 7'h37;
   localparam logic [6:0] AUIPC  = 7'h17;
   localparam logic [6:0] SYSTEM = 7'h73;

   typedef struct packed {
      logic       valid;
      logic [2:0] funct3;
      logic [6:0] opcode;
      logic [4:0] rd;
      wb_sel_e    wb_sel;
      logic       reg_wr;
      logic       csr_wr;
      logic       csr_rd;
   } ctrl_stage_t;

   // U-type and JAL carry no rs1 field; everything else reads rs1.
   function automatic logic rs1_used(input logic [6:0] opc);
      return !(opc == LUI || opc == AUIPC || opc == JAL);
   endfunction

   // Only R-type, stores and branches read rs2.
   function automatic logic rs2_used(input logic [6:0] opc);
      return (opc == OP || opc == STORE || opc == BRANCH);
   endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Priority match of one source register against all held pipeline stages.
// Combinational, zero latency.
// No backpressure; pure function of the stage contents.
module hazard_fwd_match
   import hazard_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int FWD_W = 1
) (
   input  logic [4:0]         rs_i,
   input  logic               used_i,
   input  logic [DEPTH-1:0]   stg_vld_i,
   input  logic [DEPTH-1:0]   stg_reg_wr_i,
   input  logic [5*DEPTH-1:0] stg_rd_i,
   output logic [FWD_W-1:0]   sel_o
);

   // Scan oldest to youngest so the youngest matching stage overwrites older ones.
   always_comb begin
      sel_o = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (used_i && (rs_i != 5'd0) && stg_vld_i[k] && stg_reg_wr_i[k] &&
             (stg_rd_i[5*k +: 5] == rs_i)) begin
            sel_o = FWD_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Control pipeline (DEPTH stages) with forwarding selects, load-use stall and flush handling.
// DEPTH cycles from inst_i to the output fields; forwarding and stall_o are combinational.
// stall_i freezes every stage and counter; flushes seen during stall_i are latched until release.
module hazard_pipe_ctrl
   import hazard_pkg::*;
#(
   parameter  int DEPTH          = 1,
   parameter  int LOAD_USE_STALL = 0,
   parameter  int CNT_W          = 32,
   localparam int FWD_W          = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic [31:0]      inst_i,
   input  logic             reg_wr_i,
   input  logic [1:0]       wb_sel_i,
   input  logic             csr_wr_i,
   input  logic             csr_rd_i,
   output logic             valid_o,
   output logic             reg_wr_o,
   output logic [1:0]       wb_sel_o,
   output logic [2:0]       funct3_o,
   output logic [6:0]       opcode_o,
   output logic [4:0]       rd_o,
   output logic             csr_wr_o,
   output logic             csr_rd_o,
   output logic [FWD_W-1:0] fwd_rs1_o,
   output logic [FWD_W-1:0] fwd_rs2_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctrl_stage_t      stage_q [DEPTH];
   ctrl_stage_t      stage_d [DEPTH];
   logic             flush_pend_q, flush_pend_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   ctrl_stage_t      dec;
   logic [4:0]       rs1, rs2;
   logic             rs1_use, rs2_use;
   logic             load_hit;
   logic             flush_req;
   logic [DEPTH-1:0] stg_vld, stg_reg_wr;
   logic [5*DEPTH-1:0] stg_rd;

   // Funct7/imm bits are not needed by this control path.
   logic unused_inst_hi;
   assign unused_inst_hi = ^inst_i[31:25];

   // Decode incoming instruction into a stage record and its source registers.
   always_comb begin
      dec        = '0;
      dec.valid  = valid_i;
      dec.funct3 = inst_i[14:12];
      dec.opcode = inst_i[6:0];
      dec.rd     = inst_i[11:7];
      dec.wb_sel = wb_sel_e'(wb_sel_i);
      dec.reg_wr = reg_wr_i;
      dec.csr_wr = csr_wr_i;
      dec.csr_rd = csr_rd_i;
      rs1        = inst_i[19:15];
      rs2        = inst_i[24:20];
      rs1_use    = rs1_used(inst_i[6:0]);
      rs2_use    = rs2_used(inst_i[6:0]);
   end

   // A load still in stage 0 cannot forward yet, so a dependent reader must wait a cycle.
   assign load_hit = valid_i && stage_q[0].valid && (stage_q[0].wb_sel == WB_MEM) &&
                     ((rs1_use && (rs1 != 5'd0) && (rs1 == stage_q[0].rd)) ||
                      (rs2_use && (rs2 != 5'd0) && (rs2 == stage_q[0].rd)));
   assign stall_o   = (LOAD_USE_STALL != 0) && load_hit;
   assign flush_req = (flush_i || flush_pend_q) && !stall_i;

   // Flatten stage fields for the two forwarding matchers.
   always_comb begin
      stg_vld    = '0;
      stg_reg_wr = '0;
      stg_rd     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         stg_vld[k]       = stage_q[k].valid;
         stg_reg_wr[k]    = stage_q[k].reg_wr;
         stg_rd[5*k +: 5] = stage_q[k].rd;
      end
   end

   hazard_fwd_match #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_fwd_rs1 (
      .rs_i         (rs1),
      .used_i       (rs1_use),
      .stg_vld_i    (stg_vld),
      .stg_reg_wr_i (stg_reg_wr),
      .stg_rd_i     (stg_rd),
      .sel_o        (fwd_rs1_o)
   );

   hazard_fwd_match #(.DEPTH(DEPTH), .FWD_W(FWD_W)) u_fwd_rs2 (
      .rs_i         (rs2),
      .used_i       (rs2_use),
      .stg_vld_i    (stg_vld),
      .stg_reg_wr_i (stg_reg_wr),
      .stg_rd_i     (stg_rd),
      .sel_o        (fwd_rs2_o)
   );

   // Next state: hold on stall_i, otherwise shift with flush/bubble overriding stage 0.
   always_comb begin
      stage_d      = stage_q;
      flush_pend_d = flush_pend_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (stall_i) begin
         if (flush_i) flush_pend_d = 1'b1;
      end else begin
         for (int k = DEPTH - 1; k >= 1; k--) stage_d[k] = stage_q[k-1];
         if (flush_req) begin
            stage_d[0]   = '0;
            flush_pend_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end else if (stall_o) begin
            stage_d[0] = '0;
         end else begin
            stage_d[0] = dec;
         end
         if (stall_o && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
         flush_pend_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         stage_q      <= stage_d;
         flush_pend_q <= flush_pend_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign valid_o     = stage_q[DEPTH-1].valid;
   assign reg_wr_o    = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].reg_wr;
   assign wb_sel_o    = stage_q[DEPTH-1].wb_sel;
   assign funct3_o    = stage_q[DEPTH-1].funct3;
   assign opcode_o    = stage_q[DEPTH-1].opcode;
   assign rd_o        = stage_q[DEPTH-1].rd;
   assign csr_wr_o    = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].csr_wr;
   assign csr_rd_o    = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].csr_rd;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: u1 is DEPTH=1 without load-use stall, u2 is DEPTH=2 with it.
// A per-instruction model of each pipe is checked every cycle, plus hand-computed literals.
module tb_hazard_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst, stall_i, flush_i, valid_i, reg_wr_i, csr_wr_i, csr_rd_i;
   logic [31:0] inst_i;
   logic [1:0]  wb_sel_i;

   logic        u1_valid_o, u1_reg_wr_o, u1_csr_wr_o, u1_csr_rd_o, u1_stall_o;
   logic [1:0]  u1_wb_sel_o;
   logic [2:0]  u1_funct3_o;
   logic [6:0]  u1_opcode_o;
   logic [4:0]  u1_rd_o;
   logic [0:0]  u1_fwd_rs1_o, u1_fwd_rs2_o;
   logic [31:0] u1_stall_cnt_o, u1_flush_cnt_o;

   logic        u2_valid_o, u2_reg_wr_o, u2_csr_wr_o, u2_csr_rd_o, u2_stall_o;
   logic [1:0]  u2_wb_sel_o;
   logic [2:0]  u2_funct3_o;
   logic [6:0]  u2_opcode_o;
   logic [4:0]  u2_rd_o;
   logic [1:0]  u2_fwd_rs1_o, u2_fwd_rs2_o;
   logic [31:0] u2_stall_cnt_o, u2_flush_cnt_o;

   always #5 clk = ~clk;

   hazard_pipe_ctrl #(.DEPTH(1), .LOAD_USE_STALL(0), .CNT_W(32)) u1 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .inst_i(inst_i), .reg_wr_i(reg_wr_i), .wb_sel_i(wb_sel_i), .csr_wr_i(csr_wr_i),
      .csr_rd_i(csr_rd_i), .valid_o(u1_valid_o), .reg_wr_o(u1_reg_wr_o),
      .wb_sel_o(u1_wb_sel_o), .funct3_o(u1_funct3_o), .opcode_o(u1_opcode_o),
      .rd_o(u1_rd_o), .csr_wr_o(u1_csr_wr_o), .csr_rd_o(u1_csr_rd_o),
      .fwd_rs1_o(u1_fwd_rs1_o), .fwd_rs2_o(u1_fwd_rs2_o), .stall_o(u1_stall_o),
      .stall_cnt_o(u1_stall_cnt_o), .flush_cnt_o(u1_flush_cnt_o)
   );

   hazard_pipe_ctrl #(.DEPTH(2), .LOAD_USE_STALL(1), .CNT_W(32)) u2 (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
      .inst_i(inst_i), .reg_wr_i(reg_wr_i), .wb_sel_i(wb_sel_i), .csr_wr_i(csr_wr_i),
      .csr_rd_i(csr_rd_i), .valid_o(u2_valid_o), .reg_wr_o(u2_reg_wr_o),
      .wb_sel_o(u2_wb_sel_o), .funct3_o(u2_funct3_o), .opcode_o(u2_opcode_o),
      .rd_o(u2_rd_o), .csr_wr_o(u2_csr_wr_o), .csr_rd_o(u2_csr_rd_o),
      .fwd_rs1_o(u2_fwd_rs1_o), .fwd_rs2_o(u2_fwd_rs2_o), .stall_o(u2_stall_o),
      .stall_cnt_o(u2_stall_cnt_o), .flush_cnt_o(u2_flush_cnt_o)
   );

   // Outputs of both DUTs gathered by index for the compare process.
   logic        ov [2], orw [2], ocw [2], ocr [2], ost [2];
   logic [1:0]  owb [2], of1 [2], of2 [2];
   logic [2:0]  of3 [2];
   logic [6:0]  oop [2];
   logic [4:0]  ord [2];
   logic [31:0] osc [2], ofc [2];
   assign ov[0] = u1_valid_o;   assign ov[1] = u2_valid_o;
   assign orw[0] = u1_reg_wr_o; assign orw[1] = u2_reg_wr_o;
   assign ocw[0] = u1_csr_wr_o; assign ocw[1] = u2_csr_wr_o;
   assign ocr[0] = u1_csr_rd_o; assign ocr[1] = u2_csr_rd_o;
   assign ost[0] = u1_stall_o;  assign ost[1] = u2_stall_o;
   assign owb[0] = u1_wb_sel_o; assign owb[1] = u2_wb_sel_o;
   assign of1[0] = {1'b0, u1_fwd_rs1_o}; assign of1[1] = u2_fwd_rs1_o;
   assign of2[0] = {1'b0, u1_fwd_rs2_o}; assign of2[1] = u2_fwd_rs2_o;
   assign of3[0] = u1_funct3_o; assign of3[1] = u2_funct3_o;
   assign oop[0] = u1_opcode_o; assign oop[1] = u2_opcode_o;
   assign ord[0] = u1_rd_o;     assign ord[1] = u2_rd_o;
   assign osc[0] = u1_stall_cnt_o; assign osc[1] = u2_stall_cnt_o;
   assign ofc[0] = u1_flush_cnt_o; assign ofc[1] = u2_flush_cnt_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: each held slot remembers the raw instruction word it was given.
   typedef struct packed {
      logic        v;
      logic [31:0] inst;
      logic        rw;
      logic [1:0]  wb;
      logic        cw;
      logic        cr;
   } minst_t;

   minst_t m [2][2];
   int     scnt [2];
   int     fcnt [2];
   bit     pend [2];

   function automatic bit uses1(input logic [31:0] i);
      return !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
   endfunction

   function automatic bit uses2(input logic [31:0] i);
      return i[6:0] inside {7'h33, 7'h23, 7'h63};
   endfunction

   // Slot index (age) of the youngest writer of rs, plus one; 0 if none.
   function automatic int exp_fwd(input int d, input logic [4:0] rs, input bit used);
      if (!used || rs == 5'd0) return 0;
      for (int k = 0; k <= d; k++)
         if (m[d][k].v && m[d][k].rw && m[d][k].inst[11:7] == rs) return k + 1;
      return 0;
   endfunction

   function automatic bit exp_stall(input int d);
      minst_t y;
      logic [4:0] r1, r2;
      y  = m[d][0];
      r1 = inst_i[19:15];
      r2 = inst_i[24:20];
      if (d == 0 || !valid_i || !y.v || y.wb != 2'd1) return 1'b0;
      return (uses1(inst_i) && r1 != 5'd0 && r1 == y.inst[11:7]) ||
             (uses2(inst_i) && r2 != 5'd0 && r2 == y.inst[11:7]);
   endfunction

   // Model update on each clock edge.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         automatic bit st = exp_stall(d);
         automatic bit fl = flush_i || pend[d];
         automatic minst_t nw = {valid_i, inst_i, reg_wr_i, wb_sel_i, csr_wr_i, csr_rd_i};
         if (rst) begin
            for (int k = 0; k < 2; k++) m[d][k] <= '0;
            scnt[d] <= 0;
            fcnt[d] <= 0;
            pend[d] <= 1'b0;
         end else if (stall_i) begin
            if (flush_i) pend[d] <= 1'b1;
         end else begin
            if (st) scnt[d] <= scnt[d] + 1;
            if (d == 1) m[d][1] <= m[d][0];
            m[d][0] <= (fl || st) ? minst_t'(0) : nw;
            if (fl) begin
               fcnt[d] <= fcnt[d] + 1;
               pend[d] <= 1'b0;
            end
         end
      end
   end

   // Every-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            automatic minst_t e = m[d][d];
            automatic string p = $sformatf("u%0d_", d + 1);
            chk({p, "valid"},  ov[d], e.v);
            chk({p, "reg_wr"}, orw[d], e.v & e.rw);
            chk({p, "csr_wr"}, ocw[d], e.v & e.cw);
            chk({p, "csr_rd"}, ocr[d], e.v & e.cr);
            if (e.v) begin
               chk({p, "wb_sel"}, owb[d], e.wb);
               chk({p, "funct3"}, of3[d], e.inst[14:12]);
               chk({p, "opcode"}, oop[d], e.inst[6:0]);
               chk({p, "rd"},     ord[d], e.inst[11:7]);
            end
            chk({p, "fwd_rs1"},   of1[d], exp_fwd(d, inst_i[19:15], uses1(inst_i)));
            chk({p, "fwd_rs2"},   of2[d], exp_fwd(d, inst_i[24:20], uses2(inst_i)));
            chk({p, "stall"},     ost[d], exp_stall(d));
            chk({p, "stall_cnt"}, osc[d], scnt[d]);
            chk({p, "flush_cnt"}, ofc[d], fcnt[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [31:0] i, input bit rw,
                        input logic [1:0] wb, input bit cw = 1'b0, input bit cr = 1'b0);
      valid_i  = v;
      inst_i   = i;
      reg_wr_i = rw;
      wb_sel_i = wb;
      csr_wr_i = cw;
      csr_rd_i = cr;
   endtask

   localparam logic [31:0] ADDI_X5   = 32'h00A28293;
   localparam logic [31:0] ADD_X6_X5 = 32'h00528333;
   localparam logic [31:0] CSRRW_X11 = 32'h340295F3;
   localparam logic [31:0] LUI_X0    = 32'h00000037;
   localparam logic [31:0] ADD_X6_X0 = 32'h00000333;
   localparam logic [31:0] LW_X7     = 32'h00052383;
   localparam logic [31:0] ADD_X8_X7 = 32'h00038433;
   localparam logic [31:0] LUI_X3    = 32'h000001B7;

   initial begin
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 2'd0);
      tick();
      tick();
      rst    = 1'b0;
      chk_en = 1'b1;

      // Reset state.
      @(negedge clk);
      chk("rst_u1_valid", u1_valid_o, 0);
      chk("rst_u2_valid", u2_valid_o, 0);
      chk("rst_u2_wb_sel", u2_wb_sel_o, 0);
      chk("rst_u2_stall_cnt", u2_stall_cnt_o, 0);
      chk("rst_u2_flush_cnt", u2_flush_cnt_o, 0);

      // addi x5 then add x6,x5,x5.
      tick();
      drive(1'b1, ADDI_X5, 1'b1, 2'd0);
      tick();
      drive(1'b1, ADD_X6_X5, 1'b1, 2'd0);
      @(negedge clk);
      chk("t1_u1_valid", u1_valid_o, 1);
      chk("t1_u1_rd", u1_rd_o, 5);
      chk("t1_u1_funct3", u1_funct3_o, 0);
      chk("t1_u1_opcode", u1_opcode_o, 7'h13);
      chk("t1_u1_reg_wr", u1_reg_wr_o, 1);
      chk("t1_u2_valid", u2_valid_o, 0);
      chk("t2_u2_fwd1", u2_fwd_rs1_o, 1);
      chk("t2_u2_fwd2", u2_fwd_rs2_o, 1);
      chk("t2_u1_fwd1", u1_fwd_rs1_o, 1);

      // Third reader of x5 (csrrw x11, 0x340, x5).
      tick();
      drive(1'b1, CSRRW_X11, 1'b1, 2'd3, 1'b1, 1'b1);
      @(negedge clk);
      chk("t2_u2_fwd1_age2", u2_fwd_rs1_o, 2);
      chk("t2_u2_fwd2_unused", u2_fwd_rs2_o, 0);
      chk("t2_u2_rd", u2_rd_o, 5);
      chk("t2_u1_fwd1", u1_fwd_rs1_o, 0);
      chk("t2_u1_rd", u1_rd_o, 6);

      // LUI x0 writer, then reader of x0.
      tick();
      drive(1'b1, LUI_X0, 1'b1, 2'd0);
      @(negedge clk);
      chk("csr_u1_csr_wr", u1_csr_wr_o, 1);
      chk("csr_u1_csr_rd", u1_csr_rd_o, 1);
      chk("csr_u1_wb_sel", u1_wb_sel_o, 3);
      chk("csr_u1_funct3", u1_funct3_o, 1);
      tick();
      drive(1'b1, ADD_X6_X0, 1'b1, 2'd0);
      @(negedge clk);
      chk("t3_u2_fwd1", u2_fwd_rs1_o, 0);
      chk("t3_u2_fwd2", u2_fwd_rs2_o, 0);
      chk("t3_u1_fwd1", u1_fwd_rs1_o, 0);

      // Load-use: lw x7 then add x8,x7,x0 held.
      tick();
      drive(1'b1, LW_X7, 1'b1, 2'd1);
      tick();
      drive(1'b1, ADD_X8_X7, 1'b1, 2'd0);
      @(negedge clk);
      chk("t4_u2_stall", u2_stall_o, 1);
      chk("t4_u1_stall", u1_stall_o, 0);
      chk("t4_u2_fwd1_pre", u2_fwd_rs1_o, 1);
      tick();
      @(negedge clk);
      chk("t4_u2_stall_after", u2_stall_o, 0);
      chk("t4_u2_fwd1", u2_fwd_rs1_o, 2);
      chk("t4_u2_stall_cnt", u2_stall_cnt_o, 1);
      chk("t4_u2_rd_lw", u2_rd_o, 7);
      chk("t4_u1_stall_cnt", u1_stall_cnt_o, 0);

      // Flush during stall_i for 3 cycles, then release with flush_i still high.
      tick();
      drive(1'b1, ADDI_X5, 1'b1, 2'd0);
      tick();
      drive(1'b1, ADD_X6_X5, 1'b1, 2'd0);
      tick();
      stall_i = 1'b1; flush_i = 1'b1;
      drive(1'b1, LUI_X3, 1'b1, 2'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_u2_valid_hold", u2_valid_o, 1);
         chk("t5_u2_rd_hold", u2_rd_o, 5);
         chk("t5_u1_rd_hold", u1_rd_o, 6);
         chk("t5_u2_flush_cnt_hold", u2_flush_cnt_o, 0);
         tick();
      end
      stall_i = 1'b0;
      tick();
      flush_i = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 2'd0);
      @(negedge clk);
      chk("t5_u2_flush_cnt", u2_flush_cnt_o, 1);
      chk("t5_u1_flush_cnt", u1_flush_cnt_o, 1);
      chk("t5_u1_bubble", u1_valid_o, 0);
      chk("t5_u2_valid", u2_valid_o, 1);
      chk("t5_u2_rd", u2_rd_o, 6);
      tick();
      @(negedge clk);
      chk("t5_u2_bubble", u2_valid_o, 0);
      chk("t5_u2_flush_cnt_once", u2_flush_cnt_o, 1);

      // Reset with two live stages.
      tick();
      drive(1'b1, LW_X7, 1'b1, 2'd1);
      tick();
      drive(1'b1, ADD_X6_X5, 1'b1, 2'd0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 2'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_u2_valid_pre", u2_valid_o, 1);
      chk("t6_u2_wb_sel_pre", u2_wb_sel_o, 1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_u2_valid", u2_valid_o, 0);
      chk("t6_u2_reg_wr", u2_reg_wr_o, 0);
      chk("t6_u2_wb_sel", u2_wb_sel_o, 0);
      chk("t6_u2_stall_cnt", u2_stall_cnt_o, 0);
      chk("t6_u2_flush_cnt", u2_flush_cnt_o, 0);
      chk("t6_u1_valid", u1_valid_o, 0);

      tick();
      tick();
      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
